multicycle_ctrl_112: RTL and testbench

MULTICYCLE_CTRL_112 -- requirements
Module: multicycle_ctrl_112

---
 rtl/multicycle_ctrl_112_if.sv | 28 ++
 rtl/multicycle_ctrl_112.sv | 58 +++++
 tb/tb_multicycle_ctrl_112.sv | 132 +++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_112_if.sv
// multicycle_ctrl_112_if: instruction fields, ALU flags and control outputs between datapath and controller
interface multicycle_ctrl_112_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic Zero;
  logic Overflow;
  logic PCWr;
  logic IRWr;
  logic RegWr;
  logic MemWr;
  logic RegDst;
  logic ExtOp;
  logic ALUSrc;
  logic MemtoReg;
  logic [2:0] ALUctr;
  logic [1:0] PCSrc;
  logic [2:0] state;
  logic illegal;
  logic [31:0] instr_cnt;
  modport master (
    output op, funct, Zero, Overflow,
    input PCWr, IRWr, RegWr, MemWr, RegDst, ExtOp, ALUSrc, MemtoReg, ALUctr, PCSrc, state, illegal, instr_cnt
  );
  modport slave (
    input op, funct, Zero, Overflow,
    output PCWr, IRWr, RegWr, MemWr, RegDst, ExtOp, ALUSrc, MemtoReg, ALUctr, PCSrc, state, illegal, instr_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_112.sv
// multicycle_ctrl_112: multicycle MIPS-subset controller with overflow-suppressed writeback and retire counter
module multicycle_ctrl_112 (
  input logic clk,
  input logic rst,
  multicycle_ctrl_112_if.slave bus
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  state_t st;
  logic ovf_q;
  logic [31:0] cnt;
  logic r_type, is_add, is_sub, is_slt, is_r, is_ori, is_addi, is_lw, is_sw, is_beq, is_j, legal;
  logic held, done, n;
  assign r_type  = bus.op == 6'b000000;
  assign is_add  = r_type & (bus.funct == 6'b100000);
  assign is_sub  = r_type & (bus.funct == 6'b100010);
  assign is_slt  = r_type & (bus.funct == 6'b101010);
  assign is_r    = is_add | is_sub | is_slt;
  assign is_ori  = bus.op == 6'b001101;
  assign is_addi = bus.op == 6'b001000;
  assign is_lw   = bus.op == 6'b100011;
  assign is_sw   = bus.op == 6'b101011;
  assign is_beq  = bus.op == 6'b000100;
  assign is_j    = bus.op == 6'b000010;
  assign legal   = is_r | is_ori | is_addi | is_lw | is_sw | is_beq | is_j;
  assign n       = ~rst;
  // selects stay at the instruction's value from decode through writeback
  assign held = n & legal & ~is_j & (st inside {S_ID, S_EXE, S_MEM, S_WB});
  assign done = (st == S_WB) | (st == S_MEM & is_sw) | (st == S_EXE & is_beq) | (st == S_ID & is_j);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= S_IF;
      ovf_q <= 1'b0;
      cnt <= 32'd0;
    end else begin
      case (st)
        S_IF:    st <= S_ID;
        S_ID:    st <= (is_j | ~legal) ? S_IF : S_EXE;
        S_EXE:   st <= is_beq ? S_IF : (is_lw | is_sw) ? S_MEM : S_WB;
        S_MEM:   st <= is_lw ? S_WB : S_IF;
        default: st <= S_IF;
      endcase
      if (st == S_EXE) ovf_q <= (is_add | is_sub | is_addi) & bus.Overflow;
      if (done) cnt <= cnt + 32'd1;
    end
  assign bus.state     = st;
  assign bus.instr_cnt = cnt;
  assign bus.IRWr      = n & (st == S_IF);
  assign bus.PCWr      = n & ((st == S_IF) | (st == S_ID & is_j) | (st == S_EXE & is_beq & bus.Zero));
  assign bus.RegWr     = n & (st == S_WB) & ~ovf_q;
  assign bus.MemWr     = n & (st == S_MEM) & is_sw;
  assign bus.PCSrc     = (n & st == S_ID & is_j) ? 2'b10 : (n & st == S_EXE & is_beq) ? 2'b01 : 2'b00;
  assign bus.illegal   = n & (st == S_ID) & ~legal;
  assign bus.RegDst    = held & is_r;
  assign bus.ALUSrc    = held & (is_ori | is_addi | is_lw | is_sw);
  assign bus.ExtOp     = held & ~is_ori;
  assign bus.MemtoReg  = held & is_lw;
  assign bus.ALUctr    = ~held ? 3'b000 : (is_sub | is_beq) ? 3'b001 : is_ori ? 3'b010 : is_slt ? 3'b011 : 3'b000;
endmodule

// File: tb/tb_multicycle_ctrl_112.sv
// tb_multicycle_ctrl_112: directed scoreboard bench for the multicycle controller
module tb_multicycle_ctrl_112;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [16:0] q[$];
  multicycle_ctrl_112_if bus ();
  multicycle_ctrl_112 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [16:0] rec(int s, int pw, int iw, int rw, int mw, int ps, int il,
                                      int rd, int as, int mr, int eo, int ac);
    return {s[2:0], pw[0], iw[0], rw[0], mw[0], ps[1:0], il[0], rd[0], as[0], mr[0], eo[0], ac[2:0]};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.state, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.PCSrc, bus.illegal,
            bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.ExtOp, bus.ALUctr};
  endfunction

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  // expected per-cycle outputs for one instruction, derived from the instruction table
  task automatic push_exp(input logic [5:0] o, input logic [5:0] f, input logic z, input logic v);
    int r, add, sub, slt, ori, addi, lw, sw, beq, j, legal, rd, as, mr, eo, ac;
    r = (o == 6'h00) ? 1 : 0;
    add = (r == 1 && f == 6'h20) ? 1 : 0;
    sub = (r == 1 && f == 6'h22) ? 1 : 0;
    slt = (r == 1 && f == 6'h2a) ? 1 : 0;
    ori = (o == 6'h0d) ? 1 : 0;
    addi = (o == 6'h08) ? 1 : 0;
    lw = (o == 6'h23) ? 1 : 0;
    sw = (o == 6'h2b) ? 1 : 0;
    beq = (o == 6'h04) ? 1 : 0;
    j = (o == 6'h02) ? 1 : 0;
    legal = add | sub | slt | ori | addi | lw | sw | beq | j;
    rd = add | sub | slt;
    as = ori | addi | lw | sw;
    mr = lw;
    eo = 1 - ori;
    ac = (sub | beq) ? 1 : ori ? 2 : slt ? 3 : 0;
    q.push_back(rec(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (legal == 0) q.push_back(rec(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    else if (j == 1) q.push_back(rec(1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    else begin
      q.push_back(rec(1, 0, 0, 0, 0, 0, 0, rd, as, mr, eo, ac));
      q.push_back(rec(2, beq & int'(z), 0, 0, 0, beq, 0, rd, as, mr, eo, ac));
      if (lw == 1 || sw == 1) q.push_back(rec(3, 0, 0, 0, sw, 0, 0, rd, as, mr, eo, ac));
      if (beq == 0 && sw == 0)
        q.push_back(rec(4, 0, 0, ((add | sub | addi) & int'(v)) ? 0 : 1, 0, 0, 0, rd, as, mr, eo, ac));
    end
    if (legal == 1) exp_cnt = exp_cnt + 32'd1;
  endtask

  // entered and left with the DUT in S_IF, just after a rising edge
  task automatic exec(input string name, input logic [5:0] o, input logic [5:0] f, input logic z, input logic v);
    int n;
    logic [16:0] e;
    bus.op = o;
    bus.funct = f;
    bus.Zero = z;
    bus.Overflow = v;
    push_exp(o, f, z, v);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("%s_cyc%0d", name, i), 32'(obs()), 32'(e));
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_cnt", name), bus.instr_cnt, exp_cnt);
  endtask

  initial begin
    rst = 1'b1;
    bus.op = 6'h00;
    bus.funct = 6'h20;
    bus.Zero = 1'b0;
    bus.Overflow = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 32'(obs()), 32'd0);
    chk("reset_cnt", bus.instr_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exec("add", 6'h00, 6'h20, 1'b0, 1'b0);
    exec("lw", 6'h23, 6'h15, 1'b0, 1'b0);
    exec("sw", 6'h2b, 6'h00, 1'b0, 1'b0);
    exec("beq_taken", 6'h04, 6'h00, 1'b1, 1'b0);
    exec("beq_not", 6'h04, 6'h00, 1'b0, 1'b0);
    exec("addi_ovf", 6'h08, 6'h00, 1'b0, 1'b1);
    exec("sub_ovf", 6'h00, 6'h22, 1'b0, 1'b1);
    exec("slt_flag", 6'h00, 6'h2a, 1'b1, 1'b1);
    exec("ori", 6'h0d, 6'h00, 1'b0, 1'b1);
    exec("sub", 6'h00, 6'h22, 1'b1, 1'b0);
    exec("ill_op", 6'h3f, 6'h00, 1'b0, 1'b0);
    exec("ill_funct", 6'h00, 6'h21, 1'b0, 1'b0);
    exec("j", 6'h02, 6'h00, 1'b0, 1'b0);
    exec("add_ovf", 6'h00, 6'h20, 1'b0, 1'b1);
    bus.op = 6'h2b;
    bus.funct = 6'h00;
    bus.Overflow = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    chk("sw_mem_state", 32'(bus.state), 32'd3);
    chk("sw_mem_memwr", 32'(bus.MemWr), 32'd1);
    rst = 1'b1;
    #1;
    exp_cnt = 32'd0;
    chk("async_state", 32'(bus.state), 32'd0);
    chk("async_memwr", 32'(bus.MemWr), 32'd0);
    chk("async_outputs", 32'(obs()), 32'd0);
    chk("async_cnt", bus.instr_cnt, exp_cnt);
    @(posedge clk);
    #1 rst = 1'b0;
    exec("add_after_rst", 6'h00, 6'h20, 1'b0, 1'b0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
